// File: rtl/vdp_vram_arb_pkg.sv
// Shared types for the VDP VRAM arbiter: FSM states, grant encoding and counter width.
// Optional round-robin low-priority sharing is selected with VDP_VRAM_ARB_RR_EN.
package vdp_vram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_CPU,
    GNT_CMD
  } gnt_t;

  localparam int CNT_W = 3;

  // Bit positions inside the packed request vector handed to the picker.
  localparam int REQ_DISP = 0;
  localparam int REQ_CPU  = 1;
  localparam int REQ_CMD  = 2;

  function automatic logic is_low_grant(input gnt_t g);
    return (g == GNT_CPU) || (g == GNT_CMD);
  endfunction

endpackage

// File: rtl/vdp_vram_arb_pick.sv
// Combinational winner selection: display always first, then cpu/cmd by fixed priority,
// or round-robin between cpu and cmd when VDP_VRAM_ARB_RR_EN is defined.
module vdp_vram_arb_pick
  import vdp_vram_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic       last_low_i,
  output gnt_t       gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    if (req_i[REQ_DISP]) begin
      gnt_o = GNT_DISP;
    end
`ifdef VDP_VRAM_ARB_RR_EN
    // last_low_i high means the next cpu/cmd tie goes to cmd.
    else if (req_i[REQ_CPU] && req_i[REQ_CMD]) begin
      gnt_o = last_low_i ? GNT_CMD : GNT_CPU;
    end
`endif
    else if (req_i[REQ_CPU]) begin
      gnt_o = GNT_CPU;
    end else if (req_i[REQ_CMD]) begin
      gnt_o = GNT_CMD;
    end
  end

`ifndef VDP_VRAM_ARB_RR_EN
  logic unused_last_low;
  assign unused_last_low = last_low_i;
`endif

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter: one fixed-length access at a time for display, CPU and command engine.
// Define VDP_VRAM_ARB_RR_EN to share the low priority level round-robin between cpu and cmd.
module vdp_vram_arbiter
  import vdp_vram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4,
  parameter int ADR_W         = 17
) (
  input  logic             CLK21M,
  input  logic             RESET,
  input  logic             disp_req,
  input  logic [ADR_W-1:0] disp_adr,
  output logic             disp_ack,
  input  logic             cpu_req,
  input  logic             cpu_wrt,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [7:0]       cpu_wdata,
  output logic             cpu_ack,
  input  logic             cmd_req,
  input  logic             cmd_wrt,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [7:0]       cmd_wdata,
  output logic             cmd_ack,
  output logic [15:0]      rdata,
  output logic [1:0]       grant_id,
  output logic             PRAMOE_N,
  output logic             PRAMWE_N,
  output logic [ADR_W-1:0] PRAMADR,
  input  logic [15:0]      PRAMDBI,
  output logic [7:0]       PRAMDBO
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gnt_t             gnt_q, gnt_d;
  logic             wrt_q, wrt_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [7:0]       dbo_q, dbo_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             last_low;
  logic             last_cnt;
  gnt_t             pick;

  assign last_cnt = (cnt_q == CNT_W'(ACCESS_CYCLES - 1));

  vdp_vram_arb_pick u_pick (
    .req_i      ({cmd_req, cpu_req, disp_req}),
    .last_low_i (last_low),
    .gnt_o      (pick)
  );

`ifdef VDP_VRAM_ARB_RR_EN
  logic last_low_q, last_low_d;

  always_comb begin
    last_low_d = last_low_q;
    if (state_q == ST_IDLE && is_low_grant(pick)) begin
      last_low_d = ~last_low_q;
    end
  end

  always_ff @(posedge CLK21M) begin
    if (RESET) begin
      last_low_q <= 1'b0;
    end else begin
      last_low_q <= last_low_d;
    end
  end

  assign last_low = last_low_q;
`else
  assign last_low = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    wrt_d   = wrt_q;
    adr_d   = adr_q;
    dbo_d   = dbo_q;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        gnt_d = GNT_NONE;
        if (pick != GNT_NONE) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
          gnt_d   = pick;
          unique case (pick)
            GNT_DISP: begin
              adr_d = disp_adr;
              wrt_d = 1'b0;
            end
            GNT_CPU: begin
              adr_d = cpu_adr;
              wrt_d = cpu_wrt;
              if (cpu_wrt) begin
                dbo_d = cpu_wdata;
              end
            end
            GNT_CMD: begin
              adr_d = cmd_adr;
              wrt_d = cmd_wrt;
              if (cmd_wrt) begin
                dbo_d = cmd_wdata;
              end
            end
            default: ;
          endcase
        end
      end

      ST_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_cnt) begin
          state_d = ST_DONE;
          if (!wrt_q) begin
            rdata_d = PRAMDBI;
          end
        end
      end

      ST_DONE: begin
        // Never re-grant here: the owner is still dropping its request this cycle.
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge CLK21M) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= GNT_NONE;
      wrt_q   <= 1'b0;
      adr_q   <= '0;
      dbo_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      wrt_q   <= wrt_d;
      adr_q   <= adr_d;
      dbo_q   <= dbo_d;
      rdata_q <= rdata_d;
    end
  end

  // WE_N rises one cycle before the access ends so write data holds past the rising edge.
  assign PRAMOE_N = !(state_q == ST_ACCESS && !wrt_q);
  assign PRAMWE_N = !(state_q == ST_ACCESS && wrt_q && !last_cnt);
  assign PRAMADR  = adr_q;
  assign PRAMDBO  = dbo_q;
  assign rdata    = rdata_q;
  assign grant_id = gnt_q;

  assign disp_ack = (state_q == ST_DONE) && (gnt_q == GNT_DISP);
  assign cpu_ack  = (state_q == ST_DONE) && (gnt_q == GNT_CPU);
  assign cmd_ack  = (state_q == ST_DONE) && (gnt_q == GNT_CMD);

endmodule
